// File: rtl/ifetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_if
// Description : Fetch-stage bundle: decoder controls in, instruction/PC out,
//               plus the synchronous instruction ROM port.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_if #(
    parameter int IMEM_ADDR_W = 14
);
    // control unit / decoder -> fetch
    logic                   stall;
    logic                   Branch;
    logic                   nBranch;
    logic                   Jmp;
    logic                   Jal;
    logic                   Jr;
    logic                   Zero;
    logic [31:0]            Imme_extend;
    logic [31:0]            Read_data_1;
    // instruction ROM
    logic [31:0]            imem_rdata;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    // fetch -> decoder / control unit
    logic [31:0]            Instruction;
    logic [31:0]            opcplus4;
    logic [31:0]            PC;
    logic                   inst_valid;
    logic                   fetch_fault;

    modport master (
        input  stall, Branch, nBranch, Jmp, Jal, Jr, Zero,
        input  Imme_extend, Read_data_1, imem_rdata,
        output imem_addr, Instruction, opcplus4, PC, inst_valid, fetch_fault
    );

    modport slave (
        output stall, Branch, nBranch, Jmp, Jal, Jr, Zero,
        output Imme_extend, Read_data_1, imem_rdata,
        input  imem_addr, Instruction, opcplus4, PC, inst_valid, fetch_fault
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : MIPS fetch stage: PC register, next-PC selection and sync-ROM
//               addressing. Optional jr alignment trap: IFETCH_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 14
) (
    input  wire logic  clock,
    input  wire logic  reset,
    ifetch_if.master   bus
);

`ifdef IFETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] w_pc4;
    logic [31:0] w_inst;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic        w_br_taken;
    logic        w_run;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic        fault_q, fault_d;
`endif

    assign w_run       = (state_q == RUN) && !reset;
    assign w_inst      = w_run ? bus.imem_rdata : 32'h0000_0000;
    assign w_pc4       = pc_q + 32'd4;
    assign w_br_target = w_pc4 + {bus.Imme_extend[29:0], 2'b00};
    assign w_j_target  = {w_pc4[31:28], w_inst[25:0], 2'b00};
    assign w_br_taken  = (bus.Branch && bus.Zero) || (bus.nBranch && !bus.Zero);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef IFETCH_ALIGN_CHECK_EN
        fault_d = fault_q;
`endif
        case (state_q)
            BOOT: begin
                pc_d    = RESET_PC;
                state_d = RUN;
            end
            RUN: begin
                if (!bus.stall) begin
                    if (bus.Jr) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                        if (bus.Read_data_1[1:0] != 2'b00) begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                        end else begin
                            pc_d = bus.Read_data_1;
                        end
`else
                        pc_d = bus.Read_data_1 & 32'hFFFF_FFFC;
`endif
                    end else if (bus.Jmp || bus.Jal) begin
                        pc_d = w_j_target;
                    end else if (w_br_taken) begin
                        pc_d = w_br_target;
                    end else begin
                        pc_d = w_pc4;
                    end
                end
            end
`ifdef IFETCH_ALIGN_CHECK_EN
            FAULT: begin
                pc_d = pc_q;
            end
`endif
            default: begin
                pc_d    = RESET_PC;
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= BOOT;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    // ROM latches the next PC's word on the same edge the PC register updates
    assign bus.imem_addr   = reset ? RESET_PC[IMEM_ADDR_W+1:2] : pc_d[IMEM_ADDR_W+1:2];
    assign bus.Instruction = w_inst;
    assign bus.opcplus4    = w_pc4;
    assign bus.PC          = pc_q;
    assign bus.inst_valid  = w_run;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign bus.fetch_fault = fault_q;
`else
    assign bus.fetch_fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed, table-driven bench for ifetch_unit with a sync ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;
    localparam int AW = 14;

    typedef struct {
        logic        st, br, nbr, jmp, jal, jr, zero;
        logic [31:0] imm;
        logic [31:0] rd1;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] rom [0:(1<<AW)-1];
    vec_t        vec [0:22];

    ifetch_if #(.IMEM_ADDR_W(AW)) bus ();

    ifetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(AW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

    function automatic vec_t mk(input logic st, br, nbr, jmp, jal, jr, zero,
                                input logic [31:0] imm, rd1, pc, addr);
        vec_t v;
        v.st = st; v.br = br; v.nbr = nbr; v.jmp = jmp; v.jal = jal;
        v.jr = jr; v.zero = zero; v.imm = imm; v.rd1 = rd1;
        v.exp_pc = pc; v.exp_addr = addr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall = v.st; bus.Branch = v.br; bus.nBranch = v.nbr;
        bus.Jmp = v.jmp; bus.Jal = v.jal; bus.Jr = v.jr; bus.Zero = v.zero;
        bus.Imme_extend = v.imm; bus.Read_data_1 = v.rd1;
    endtask

    task automatic idle();
        drive(mk(0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0));
    endtask

    // one RUN cycle: drive just after the edge, sample mid-cycle
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] ix;
        @(posedge clk); #1;
        drive(v);
        #4;
        ix = {18'h0, v.exp_pc[15:2]};
        check($sformatf("v%0d PC", idx),       bus.PC, v.exp_pc);
        check($sformatf("v%0d opcplus4", idx), bus.opcplus4, v.exp_pc + 32'd4);
        check($sformatf("v%0d imem_addr", idx), {18'h0, bus.imem_addr}, v.exp_addr);
        check($sformatf("v%0d Instruction", idx), bus.Instruction, rom[ix]);
        check($sformatf("v%0d inst_valid", idx), {31'h0, bus.inst_valid}, 32'd1);
        check($sformatf("v%0d fetch_fault", idx), {31'h0, bus.fetch_fault}, 32'd0);
    endtask

    task automatic reset_and_boot(input string tag);
        @(posedge clk); #1;
        rst = 1'b1;
        // controls asserted during reset must not matter
        drive(mk(1,1,0,1,0,1,1, 32'h10, 32'h44, 32'h0, 32'h0));
        @(posedge clk); #1;
        check({tag, " rst imem_addr"}, {18'h0, bus.imem_addr}, 32'h0);
        check({tag, " rst inst_valid"}, {31'h0, bus.inst_valid}, 32'd0);
        check({tag, " rst Instruction"}, bus.Instruction, 32'h0);
        rst = 1'b0;
        idle();
        #4;
        check({tag, " boot PC"}, bus.PC, 32'h0);
        check({tag, " boot inst_valid"}, {31'h0, bus.inst_valid}, 32'd0);
        check({tag, " boot Instruction"}, bus.Instruction, 32'h0);
        check({tag, " boot opcplus4"}, bus.opcplus4, 32'h4);
        check({tag, " boot fetch_fault"}, {31'h0, bus.fetch_fault}, 32'd0);
        check({tag, " boot imem_addr"}, {18'h0, bus.imem_addr}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) rom[i] = {16'hAC00, i[15:0]};
        rom[0] = 32'h2008_0005;
        rom[8] = 32'h0C00_0040;   // jal 0x40

        //              st br nb jm jl jr z  imm            rd1            pc             addr
        vec[0]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0000, 32'h1);
        vec[1]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0004, 32'h2);
        vec[2]  = mk(1, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0,         32'h0000_0008, 32'h2);
        vec[3]  = mk(1, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0,         32'h0000_0008, 32'h2);
        vec[4]  = mk(1, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0,         32'h0000_0008, 32'h2);
        vec[5]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0008, 32'h3);
        vec[6]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_000C, 32'h4);
        vec[7]  = mk(0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0,         32'h0000_0010, 32'h3);
        vec[8]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_000C, 32'h4);
        vec[9]  = mk(0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFE, 32'h0,         32'h0000_0010, 32'h5);
        vec[10] = mk(0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFE, 32'h0,         32'h0000_0014, 32'h4);
        vec[11] = mk(0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFE, 32'h0,         32'h0000_0010, 32'h3);
        vec[12] = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,         32'h0000_0020, 32'h0000_000C, 32'h8);
        vec[13] = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,         32'h0,         32'h0000_0020, 32'h40);
        vec[14] = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,         32'h0000_0024, 32'h0000_0100, 32'h9);
        vec[15] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0024, 32'hA);
        vec[16] = mk(0, 1, 0, 1, 0, 1, 1, 32'h10,        32'h0000_0030, 32'h0000_0028, 32'hC);
        vec[17] = mk(0, 1, 0, 1, 0, 0, 1, 32'h10,        32'h0,         32'h0000_0030, 32'hC);
        vec[18] = mk(0, 0, 1, 0, 0, 0, 1, 32'h5,         32'h0,         32'h0000_0030, 32'hD);
        vec[19] = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0034, 32'h3FFF);
        vec[20] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0);
        vec[21] = mk(0, 1, 0, 0, 0, 0, 1, 32'h10,        32'h0,         32'h0000_0000, 32'h11);
        vec[22] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0044, 32'h12);

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        reset_and_boot("init");

        for (int i = 0; i <= 22; i++) run_vec(vec[i], i);

        // misaligned jr at PC 0x48
        @(posedge clk); #1;
        drive(mk(0,0,0,0,0,1,0, 32'h0, 32'h0000_0026, 32'h0, 32'h0));
        #4;
        check("mis PC", bus.PC, 32'h48);
`ifdef IFETCH_ALIGN_CHECK_EN
        check("mis imem_addr", {18'h0, bus.imem_addr}, 32'h12);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive(mk(0,1,0,0,0,0,1, 32'h4, 32'h0, 32'h0, 32'h0));
            #4;
            check($sformatf("fault%0d PC", k), bus.PC, 32'h48);
            check($sformatf("fault%0d fetch_fault", k), {31'h0, bus.fetch_fault}, 32'd1);
            check($sformatf("fault%0d inst_valid", k), {31'h0, bus.inst_valid}, 32'd0);
            check($sformatf("fault%0d Instruction", k), bus.Instruction, 32'h0);
            check($sformatf("fault%0d imem_addr", k), {18'h0, bus.imem_addr}, 32'h12);
        end
`else
        check("mis imem_addr", {18'h0, bus.imem_addr}, 32'h9);
        @(posedge clk); #1;
        idle();
        #4;
        check("mis next PC", bus.PC, 32'h24);
        check("mis inst_valid", {31'h0, bus.inst_valid}, 32'd1);
        check("mis Instruction", bus.Instruction, rom[9]);
        check("mis fetch_fault", {31'h0, bus.fetch_fault}, 32'd0);
`endif

        reset_and_boot("rerun");
        run_vec(vec[0], 100);
        run_vec(vec[1], 101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got stuck expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
